cpu_bus_ctrl: RTL and testbench
===============================

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 Parameter NSRC, default 4, number of CPU read-data sources (1..8).
REQ-002 Parameter MEM_WAIT, default 2, wait states (in clk_enable pulses) inserted per slow-memory access in turbo.
REQ-003 Parameter IDLE_DATA, default 8'hFF, floating-bus value driven when no source is enabled.
REQ-004 clk  in  1  master clock, 28 MHz.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 turbo  in  2  speed select: 00 = /8 (3.5 MHz), 01 = /4, 10 = /2, 11 = /1.
REQ-007 mreq_n, iorq_n, rd_n, wr_n, m1_n  in  1 each  CPU bus strobes.
REQ-008 busak_n  in  1  CPU bus-acknowledge.
REQ-009 slow_mem  in  1  current address decodes to slow memory.
REQ-010 ext_wait  in  1  peripheral wait request, active-high.
REQ-011 busrq_ext_n  in  1  asynchronous DMA bus request, active-low.
REQ-012 src_oe  in  NSRC  per-source read enable.
REQ-013 src_data  in  8*NSRC  per-source data, source i at bits [8i+7:8i].
REQ-014 clk_enable  out  1  CPU clock-enable pulse.
REQ-015 wait_n  out  1  CPU WAIT_n.
REQ-016 busrq_n  out  1  synchronised bus request to CPU.
REQ-017 dma_grant  out  1  bus granted to DMA.
REQ-018 cpu_di  out  8  CPU data input.

Function
REQ-019 3-bit free-running divider counter; clk_enable SHALL be high for exactly one clk when the counter's low bits selected by the active ratio are all zero (/1: every cycle).
REQ-020 A turbo change SHALL be adopted only when the counter equals 0; no clk_enable pulse gap shorter than either ratio's period is permitted.
REQ-021 Wait FSM states IDLE, COUNT, DONE; transitions are evaluated only on clk_enable cycles.
REQ-022 IDLE->COUNT on first clk_enable with mreq_n=0, slow_mem=1, active turbo!=00; load counter with MEM_WAIT; wait_n=0 while in COUNT.
REQ-023 COUNT decrements per clk_enable; at 1 -> DONE, wait_n=1.
REQ-024 DONE->IDLE when mreq_n=1; a new access SHALL NOT retrigger until then.
REQ-025 MEM_WAIT=0 SHALL never leave IDLE.
REQ-026 wait_n SHALL additionally be low whenever ext_wait was high at the previous clk edge (registered OR).
REQ-027 I/O cycles (iorq_n=0) SHALL NOT trigger the FSM.
REQ-028 cpu_di registered each clk: lowest-index source with src_oe=1 wins; none -> IDLE_DATA; latency 1 clk.
REQ-029 cpu_di SHALL be IDLE_DATA when rd_n=1 regardless of src_oe.
REQ-030 busrq_ext_n passes through a 2-flop synchroniser to busrq_n (2 clk latency).
REQ-031 dma_grant = registered (busak_n==0 and busrq_n==0); while dma_grant=1 the FSM SHALL be forced to IDLE and wait_n=1.

Reset
REQ-032 On reset_n=0 asynchronously: divider=0, turbo register=00, FSM=IDLE, wait_n=1, clk_enable=0, busrq_n=1, dma_grant=0, cpu_di=IDLE_DATA.
REQ-033 Reset mid-wait SHALL release wait_n immediately; first clk_enable after release arrives at divider wrap in /8 mode.

Configuration
REQ-034 Macro TURBO_MEM_WAIT_EN: defined -> REQ-021..REQ-025 active; undefined -> FSM omitted, slow_mem ignored, wait_n driven solely by REQ-026/REQ-031.

Structure
REQ-035 Shared package holds turbo encoding constants (TURBO_3M5, TURBO_7M, TURBO_14M, TURBO_28M) and FSM state encodings.
REQ-036 One sub-module: cpu_ce_divider (REQ-019/REQ-020); all else inline.

Verification
REQ-037 Turbo 00, 64 clk -> exactly 8 clk_enable pulses, 8 clk apart; switch to 11 mid-period -> adopted only at counter 0, then every clk.
REQ-038 Turbo 10, MEM_WAIT=2, mreq_n low with slow_mem=1 -> wait_n low for exactly 2 clk_enable pulses (4 clk), stays high until mreq_n rises.
REQ-039 Turbo 00 same access -> wait_n stays 1; iorq_n access with slow_mem=1 at turbo 11 -> no wait.
REQ-040 src_oe=4'b0110, src1=8'h3C, src2=8'hA5, rd_n=0 -> cpu_di=8'h3C after 1 clk; src_oe=0 -> 8'hFF.
REQ-041 busrq_ext_n falls -> busrq_n low after 2 clk; busak_n low -> dma_grant=1 next clk, wait_n forced 1 during active wait.
REQ-042 reset_n pulsed during COUNT -> wait_n=1 and cpu_di=8'hFF without clock edge; build without TURBO_MEM_WAIT_EN -> scenario REQ-038 gives no wait.

Source files
------------

// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared turbo encodings, wait-FSM states and clock-enable match helper for cpu_bus_ctrl.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cpu_bus_ctrl_pkg;

  // Turbo speed select: CPU clock = 28 MHz / ratio.
  localparam logic [1:0] TURBO_3M5 = 2'b00;  // /8
  localparam logic [1:0] TURBO_7M  = 2'b01;  // /4
  localparam logic [1:0] TURBO_14M = 2'b10;  // /2
  localparam logic [1:0] TURBO_28M = 2'b11;  // /1

  // Slow-memory wait-state FSM.
  typedef enum logic [1:0] {
    WS_IDLE  = 2'd0,
    WS_COUNT = 2'd1,
    WS_DONE  = 2'd2
  } wait_state_t;

  // True when the divider count lands on a CPU clock edge for the given ratio.
  function automatic logic ce_match(input logic [2:0] cnt, input logic [1:0] ratio);
    case (ratio)
      TURBO_3M5: return (cnt == 3'd0);
      TURBO_7M:  return (cnt[1:0] == 2'd0);
      TURBO_14M: return (cnt[0] == 1'b0);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ce_divider.sv
// CPU clock-enable generator: 3-bit free-running divider, ratio switched only at count 0.
// Latency: clk_enable is registered; first pulse one clk after reset release.
// Backpressure: none, free-running.
module cpu_ce_divider
  import cpu_bus_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] turbo,
  output logic       clk_enable,
  output logic [1:0] turbo_act
);

  logic [2:0] cnt;
  logic [1:0] ratio_q;
  logic [1:0] ratio_eff;

  // A new ratio takes effect on the wrap cycle, so no pulse gap is shorter than either period.
  assign ratio_eff = (cnt == 3'd0) ? turbo : ratio_q;
  assign turbo_act = ratio_q;

  // Divider count, adopted ratio and the registered enable pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 3'd0;
      ratio_q    <= TURBO_3M5;
      clk_enable <= 1'b0;
    end else begin
      cnt        <= cnt + 3'd1;
      ratio_q    <= ratio_eff;
      clk_enable <= ce_match(cnt, ratio_eff);
    end
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: clock enable, slow-memory/peripheral WAIT, DMA bus request/grant, read-data mux.
// Latency: cpu_di 1 clk, busrq_n 2 clk, dma_grant 1 clk, ext_wait -> wait_n 1 clk.
// Backpressure: wait_n stalls the CPU; TURBO_MEM_WAIT_EN enables slow-memory wait states in turbo.
module cpu_bus_ctrl
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int         NSRC      = 4,
  parameter int         MEM_WAIT  = 2,
  parameter logic [7:0] IDLE_DATA = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        turbo,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  input  logic              busak_n,
  input  logic              slow_mem,
  input  logic              ext_wait,
  input  logic              busrq_ext_n,
  input  logic [NSRC-1:0]   src_oe,
  input  logic [8*NSRC-1:0] src_data,
  output logic              clk_enable,
  output logic              wait_n,
  output logic              busrq_n,
  output logic              dma_grant,
  output logic [7:0]        cpu_di
);

  logic [1:0] turbo_act;
  logic       ext_wait_q;
  logic       busrq_sync;
  logic [7:0] di_next;
  logic       mem_hold;

  cpu_ce_divider u_ce_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .turbo      (turbo),
    .clk_enable (clk_enable),
    .turbo_act  (turbo_act)
  );

  // Registered peripheral wait, 2-flop DMA request synchroniser and bus grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_wait_q <= 1'b0;
      busrq_sync <= 1'b1;
      busrq_n    <= 1'b1;
      dma_grant  <= 1'b0;
    end else begin
      ext_wait_q <= ext_wait;
      busrq_sync <= busrq_ext_n;
      busrq_n    <= busrq_sync;
      dma_grant  <= !busak_n && !busrq_n;
    end
  end

  // Read mux: lowest-index enabled source wins; floating bus when not reading.
  always_comb begin
    di_next = IDLE_DATA;
    if (!rd_n) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (src_oe[i]) di_next = src_data[8*i +: 8];
      end
    end
  end

  // Register CPU read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_di <= IDLE_DATA;
    else          cpu_di <= di_next;
  end

`ifdef TURBO_MEM_WAIT_EN
  wait_state_t state, state_nxt;
  logic [7:0]  wcnt, wcnt_nxt;

  // Wait FSM state and wait-state counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WS_IDLE;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state: stepped on CPU clock enables only; a DMA grant parks the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (dma_grant) begin
      state_nxt = WS_IDLE;
    end else if (clk_enable) begin
      case (state)
        WS_IDLE: begin
          if (!mreq_n && iorq_n && slow_mem && (turbo_act != TURBO_3M5) && (MEM_WAIT != 0)) begin
            state_nxt = WS_COUNT;
            wcnt_nxt  = 8'(MEM_WAIT);
          end
        end
        WS_COUNT: begin
          if (wcnt <= 8'd1) state_nxt = WS_DONE;
          else              wcnt_nxt  = wcnt - 8'd1;
        end
        WS_DONE: begin
          // Hold until the access ends so the same access cannot retrigger.
          if (mreq_n) state_nxt = WS_IDLE;
        end
        default: state_nxt = WS_IDLE;
      endcase
    end
  end

  assign mem_hold = (state == WS_COUNT);
`else
  assign mem_hold = 1'b0;
`endif

  // Grant always releases WAIT; otherwise wait on slow memory or a peripheral.
  assign wait_n = dma_grant | ~(mem_hold | ext_wait_q);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl (NSRC=4, MEM_WAIT=2, IDLE_DATA=8'hFF).
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_bus_ctrl;
  localparam int NSRC = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [1:0]        turbo = 2'b00;
  logic              mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic              busak_n = 1'b1, slow_mem = 1'b0, ext_wait = 1'b0, busrq_ext_n = 1'b1;
  logic [NSRC-1:0]   src_oe = '0;
  logic [8*NSRC-1:0] src_data = '0;
  logic              clk_enable, wait_n, busrq_n, dma_grant;
  logic [7:0]        cpu_di;

  int vectors = 0;
  int miscompares = 0;

  logic       bq[$];
  int         iq[$];
  logic [7:0] dq[$];

  cpu_bus_ctrl #(.NSRC(NSRC), .MEM_WAIT(2), .IDLE_DATA(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .turbo(turbo), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .busak_n(busak_n), .slow_mem(slow_mem),
    .ext_wait(ext_wait), .busrq_ext_n(busrq_ext_n), .src_oe(src_oe), .src_data(src_data),
    .clk_enable(clk_enable), .wait_n(wait_n), .busrq_n(busrq_n), .dma_grant(dma_grant),
    .cpu_di(cpu_di)
  );

  always #5 clk = ~clk;

`ifdef TURBO_MEM_WAIT_EN
  localparam bit MEMW = 1'b1;
`else
  localparam bit MEMW = 1'b0;
`endif

  // Reference read mux: scan upward, first enabled source is taken.
  function automatic logic [7:0] pick(input logic rd, input logic [NSRC-1:0] oe,
                                      input logic [8*NSRC-1:0] d);
    logic [7:0] r;
    bit found;
    r = 8'hFF;
    found = 0;
    if (!rd) begin
      for (int i = 0; i < NSRC; i++) begin
        if (oe[i] && !found) begin
          r = d[8*i +: 8];
          found = 1;
        end
      end
    end
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #2;
    vectors++; if (clk_enable !== 1'b0) begin miscompares++; $display("FAIL rst_ce: got %b want 0", clk_enable); end
    vectors++; if (wait_n !== 1'b1) begin miscompares++; $display("FAIL rst_wait_n: got %b want 1", wait_n); end
    vectors++; if (busrq_n !== 1'b1) begin miscompares++; $display("FAIL rst_busrq_n: got %b want 1", busrq_n); end
    vectors++; if (dma_grant !== 1'b0) begin miscompares++; $display("FAIL rst_dma_grant: got %b want 0", dma_grant); end
    vectors++; if (cpu_di !== 8'hFF) begin miscompares++; $display("FAIL rst_cpu_di: got %h want ff", cpu_di); end
    cycles(2);
    vectors++; if (clk_enable !== 1'b0) begin miscompares++; $display("FAIL rst_ce_held: got %b want 0", clk_enable); end
    reset_n = 1'b1;
  endtask

  // Starts on the negedge of reset release; sample s sees the pulse of divider count s mod 8.
  task automatic test_divider;
    int pulses, last;
    pulses = 0;
    last = -1;
    for (int s = 0; s < 64; s++) begin
      bq.push_back((s % 8) == 0);
      @(negedge clk);
      vectors++;
      if (clk_enable !== bq[0]) begin
        miscompares++; $display("FAIL div8_ce s=%0d: got %b want %b", s, clk_enable, bq[0]);
      end
      void'(bq.pop_front());
      if (clk_enable === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (s - last != 8) begin miscompares++; $display("FAIL div8_gap: got %0d want 8", s - last); end
        end
        last = s;
        pulses++;
      end
    end
    iq.push_back(8);
    vectors++; if (pulses != iq[0]) begin miscompares++; $display("FAIL div8_count: got %0d want %0d", pulses, iq[0]); end
    void'(iq.pop_front());
  endtask

  // Switch to /1 at count 3; the /8 ratio must hold until the next wrap.
  task automatic test_turbo_switch;
    for (int s = 64; s < 80; s++) begin
      bq.push_back((s < 72) ? ((s % 8) == 0) : 1'b1);
      @(negedge clk);
      vectors++;
      if (clk_enable !== bq[0]) begin
        miscompares++; $display("FAIL switch_ce s=%0d: got %b want %b", s, clk_enable, bq[0]);
      end
      void'(bq.pop_front());
      if (s == 66) turbo = 2'b11;
    end
  endtask

  task automatic test_mem_wait;
    int low, low_pulses, relow;
    bit seen_low, ended, found;
    turbo = 2'b10;
    cycles(8);
    iq.push_back(MEMW ? 4 : 0);
    iq.push_back(MEMW ? 2 : 0);
    iq.push_back(0);
    mreq_n = 1'b0;
    slow_mem = 1'b1;
    low = 0; low_pulses = 0; relow = 0; seen_low = 0; ended = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wait_n === 1'b0) begin
        if (ended) relow++;
        low++;
        seen_low = 1;
        if (clk_enable === 1'b1) low_pulses++;
      end else if (seen_low) begin
        ended = 1;
      end
    end
    vectors++; if (low != iq[0]) begin miscompares++; $display("FAIL memwait_clks: got %0d want %0d", low, iq[0]); end
    void'(iq.pop_front());
    vectors++; if (low_pulses != iq[0]) begin miscompares++; $display("FAIL memwait_pulses: got %0d want %0d", low_pulses, iq[0]); end
    void'(iq.pop_front());
    vectors++; if (relow != iq[0]) begin miscompares++; $display("FAIL memwait_retrigger: got %0d want %0d", relow, iq[0]); end
    void'(iq.pop_front());
    // A new access after mreq_n rises must wait again.
    mreq_n = 1'b1;
    cycles(4);
    bq.push_back(MEMW);
    mreq_n = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wait_n === 1'b0) found = 1;
    end
    vectors++; if (found != bq[0]) begin miscompares++; $display("FAIL memwait_new_access: got %b want %b", found, bq[0]); end
    void'(bq.pop_front());
    mreq_n = 1'b1;
    slow_mem = 1'b0;
    cycles(12);
  endtask

  task automatic test_no_wait;
    int low;
    turbo = 2'b00;
    cycles(8);
    iq.push_back(0);
    mreq_n = 1'b0;
    slow_mem = 1'b1;
    low = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (wait_n !== 1'b1) low++;
    end
    vectors++; if (low != iq[0]) begin miscompares++; $display("FAIL nowait_3m5: got %0d low clks want %0d", low, iq[0]); end
    void'(iq.pop_front());
    mreq_n = 1'b1;
    turbo = 2'b11;
    cycles(8);
    iq.push_back(0);
    iorq_n = 1'b0;
    low = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (wait_n !== 1'b1) low++;
    end
    vectors++; if (low != iq[0]) begin miscompares++; $display("FAIL nowait_io: got %0d low clks want %0d", low, iq[0]); end
    void'(iq.pop_front());
    iorq_n = 1'b1;
    slow_mem = 1'b0;
    cycles(2);
  endtask

  task automatic test_ext_wait;
    ext_wait = 1'b1;
    bq.push_back(1'b0);
    @(negedge clk);
    vectors++; if (wait_n !== bq[0]) begin miscompares++; $display("FAIL extwait_on: got %b want %b", wait_n, bq[0]); end
    void'(bq.pop_front());
    ext_wait = 1'b0;
    bq.push_back(1'b1);
    @(negedge clk);
    vectors++; if (wait_n !== bq[0]) begin miscompares++; $display("FAIL extwait_off: got %b want %b", wait_n, bq[0]); end
    void'(bq.pop_front());
  endtask

  task automatic test_read_mux;
    logic [4:0] tab[7];
    tab = '{5'b0_0110, 5'b0_0000, 5'b1_0110, 5'b0_0100, 5'b0_1000, 5'b0_1111, 5'b0_1100};
    src_data = {8'hC7, 8'hA5, 8'h3C, 8'h11};
    for (int t = 0; t < 23; t++) begin
      if (t < 7) begin
        rd_n = tab[t][4];
        src_oe = tab[t][3:0];
      end else begin
        rd_n = ($urandom_range(0, 3) == 0);
        src_oe = NSRC'($urandom);
        src_data = {$urandom, $urandom} >> 0;
      end
      dq.push_back(pick(rd_n, src_oe, src_data));
      @(negedge clk);
      vectors++;
      if (cpu_di !== dq[0]) begin
        miscompares++; $display("FAIL read_mux t=%0d: got %h want %h", t, cpu_di, dq[0]);
      end
      void'(dq.pop_front());
    end
    rd_n = 1'b1;
    src_oe = '0;
    cycles(1);
  endtask

  task automatic test_dma;
    bit found;
    busrq_ext_n = 1'b0;
    @(negedge clk);
    vectors++; if (busrq_n !== 1'b1) begin miscompares++; $display("FAIL busrq_1clk: got %b want 1", busrq_n); end
    @(negedge clk);
    vectors++; if (busrq_n !== 1'b0) begin miscompares++; $display("FAIL busrq_2clk: got %b want 0", busrq_n); end
    if (MEMW) begin
      mreq_n = 1'b0;
      slow_mem = 1'b1;
    end else begin
      ext_wait = 1'b1;
    end
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (wait_n === 1'b0) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL dma_wait_start: got no wait in 30 clk want wait_n=0"); end
    busak_n = 1'b0;
    @(negedge clk);
    vectors++; if (dma_grant !== 1'b1) begin miscompares++; $display("FAIL dma_grant_on: got %b want 1", dma_grant); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (wait_n !== 1'b1) begin miscompares++; $display("FAIL dma_wait_forced k=%0d: got %b want 1", k, wait_n); end
      @(negedge clk);
    end
    mreq_n = 1'b1; slow_mem = 1'b0; ext_wait = 1'b0;
    busak_n = 1'b1; busrq_ext_n = 1'b1;
    @(negedge clk);
    vectors++; if (dma_grant !== 1'b0) begin miscompares++; $display("FAIL dma_grant_off: got %b want 0", dma_grant); end
    cycles(3);
    vectors++; if (busrq_n !== 1'b1) begin miscompares++; $display("FAIL busrq_release: got %b want 1", busrq_n); end
  endtask

  task automatic test_reset_mid_wait;
    bit found;
    turbo = 2'b10;
    cycles(8);
    rd_n = 1'b0;
    src_oe = 4'b0001;
    src_data = {8'hC7, 8'hA5, 8'h3C, 8'h55};
    if (MEMW) begin
      mreq_n = 1'b0;
      slow_mem = 1'b1;
    end else begin
      ext_wait = 1'b1;
    end
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (wait_n === 1'b0) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_wait_start: got no wait in 30 clk want wait_n=0"); end
    vectors++; if (cpu_di !== 8'h55) begin miscompares++; $display("FAIL rstmid_di_before: got %h want 55", cpu_di); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (wait_n !== 1'b1) begin miscompares++; $display("FAIL rstmid_wait_n: got %b want 1", wait_n); end
    vectors++; if (cpu_di !== 8'hFF) begin miscompares++; $display("FAIL rstmid_cpu_di: got %h want ff", cpu_di); end
    vectors++; if (clk_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_ce: got %b want 0", clk_enable); end
    turbo = 2'b00;
    mreq_n = 1'b1; slow_mem = 1'b0; ext_wait = 1'b0;
    rd_n = 1'b1; src_oe = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 9; s++) begin
      bq.push_back((s == 0) || (s == 8));
      @(negedge clk);
      vectors++;
      if (clk_enable !== bq[0]) begin
        miscompares++; $display("FAIL rstmid_ce_after s=%0d: got %b want %b", s, clk_enable, bq[0]);
      end
      void'(bq.pop_front());
    end
  endtask

  initial begin
    test_reset;
    test_divider;
    test_turbo_switch;
    test_mem_wait;
    test_no_wait;
    test_ext_wait;
    test_read_mux;
    test_dma;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
